// File: rtl/prog_loader.sv
// prog_loader: receives a little-endian byte stream (length, base, then
// instruction byte pairs) and writes 9-bit instructions into instruction
// memory. After the last write it pulses start/start_addr so the program
// counter begins at the loaded base address. A malformed stream sets a
// sticky error flag, which only the next load clears.
module prog_loader #(
    parameter  int ROM_SIZE    = 512,
    parameter  int INSTR_WIDTH = 9,
    parameter  int BYTE_WIDTH  = 8,
    localparam int AW          = $clog2(ROM_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [BYTE_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   start,
    output logic [AW-1:0]          start_addr,
    output logic                   busy,
    output logic                   error
);

    // Length and base header fields are each two stream bytes wide.
    localparam int LW = 2 * BYTE_WIDTH;

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, BASE_LO, BASE_HI, DATA_LO, DATA_HI, LAUNCH, ERROR
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LW-1:0]          r_len;
    logic [LW-1:0]          r_base;
    logic [BYTE_WIDTH-1:0]  r_lo;
    logic [AW-1:0]          r_addr;
    logic [LW-1:0]          r_remaining;
    logic                   r_wr_en;
    logic [AW-1:0]          r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;

    logic                   w_accept;
    logic                   w_wr_fire;
    logic [LW-1:0]          w_base;
    logic [LW:0]            w_end;
    logic                   w_range_bad;
    logic                   w_hi_bad;

    assign w_accept    = s_valid && s_ready;
    // Full base as it will look once the current (BASE_HI) byte is taken.
    assign w_base      = {s_data, r_base[BYTE_WIDTH-1:0]};
    // One extra bit so B+N can never wrap before the range compare.
    assign w_end       = {1'b0, w_base} + {1'b0, r_len};
    assign w_range_bad = w_end > (LW + 1)'(ROM_SIZE);
    // Only bit 0 of the high byte carries instruction data.
    assign w_hi_bad    = s_data[BYTE_WIDTH-1:1] != '0;

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the state-derived handshake and status outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_wr_fire    = 1'b0;
        s_ready      = 1'b0;
        busy         = 1'b0;
        error        = 1'b0;
        start        = 1'b0;
        start_addr   = '0;
        case (r_state)
            IDLE: begin
                if (load) w_state_next = LEN_LO;
            end
            LEN_LO: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) w_state_next = LEN_HI;
            end
            LEN_HI: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) w_state_next = BASE_LO;
            end
            BASE_LO: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) w_state_next = BASE_HI;
            end
            BASE_HI: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    if (w_range_bad)     w_state_next = ERROR;
                    else if (r_len == '0) w_state_next = LAUNCH;
                    else                 w_state_next = DATA_LO;
                end
            end
            DATA_LO: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) w_state_next = DATA_HI;
            end
            DATA_HI: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    if (w_hi_bad) begin
                        w_state_next = ERROR;
                    end else begin
                        w_wr_fire    = 1'b1;
                        w_state_next = (r_remaining == LW'(1)) ? LAUNCH : DATA_LO;
                    end
                end
            end
            LAUNCH: begin
                busy = 1'b1;
                // Hold off one cycle while the final write strobe is out, so
                // start never overlaps wr_en.
                if (!r_wr_en) begin
                    start        = 1'b1;
                    start_addr   = r_base[AW-1:0];
                    w_state_next = IDLE;
                end
            end
            ERROR: begin
                error = 1'b1;
                if (load) w_state_next = LEN_LO;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Header capture, pair assembly and the registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_base      <= '0;
            r_lo        <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= w_wr_fire;
            if (w_accept) begin
                case (r_state)
                    LEN_LO:  r_len[BYTE_WIDTH-1:0]   <= s_data;
                    LEN_HI:  r_len[LW-1:BYTE_WIDTH]  <= s_data;
                    BASE_LO: r_base[BYTE_WIDTH-1:0]  <= s_data;
                    BASE_HI: begin
                        r_base[LW-1:BYTE_WIDTH] <= s_data;
                        r_addr                  <= w_base[AW-1:0];
                        r_remaining             <= r_len;
                    end
                    DATA_LO: r_lo <= s_data;
                    default: ;
                endcase
            end
            // Address and data hold their last values between strobes.
            if (w_wr_fire) begin
                r_wr_addr   <= r_addr;
                r_wr_data   <= {s_data[0], r_lo};
                r_addr      <= r_addr + AW'(1);
                r_remaining <= r_remaining - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed streams from the test plan
// plus randomized sessions, checked against a stream-level reference model.
module tb_prog_loader;

    localparam int ROM_SIZE = 512;
    localparam int AW       = $clog2(ROM_SIZE) + 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          load    = 1'b0;
    logic [7:0]    s_data  = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          error;

    prog_loader #(.ROM_SIZE(ROM_SIZE), .INSTR_WIDTH(9), .BYTE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus stream and reference model results.
    logic [7:0] stim[$];
    int m_wa[$];
    int m_wd[$];
    int m_n, m_base, m_consumed;
    bit m_err;

    // Interpret the stream by the format rules: what gets written, how many
    // bytes the loader consumes, and whether the session ends in error.
    task automatic build_model();
        int lo, hi;
        m_wa.delete();
        m_wd.delete();
        m_n        = {stim[1], stim[0]};
        m_base     = {stim[3], stim[2]};
        m_err      = 1'b0;
        m_consumed = 4;
        if (m_base + m_n > ROM_SIZE) begin
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < m_n; k++) begin
                lo = stim[4 + 2*k];
                hi = stim[5 + 2*k];
                m_consumed += 2;
                if (hi > 1) begin
                    m_err = 1'b1;
                    break;
                end
                m_wa.push_back(m_base + k);
                m_wd.push_back(hi * 256 + lo);
            end
        end
    endtask

    // Load a directed stream, first byte in the most significant position.
    task automatic load_stim(input int nbytes, input logic [127:0] v);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(v[(nbytes-1-i)*8 +: 8]);
    endtask

    // Monitor: cycle count, accepted bytes, observed writes and starts.
    int cyc = 0;
    int last_acc_cyc = -100;
    int sess_acc = 0;
    int mon_wa[$];
    int mon_wd[$];
    int mon_wc[$];
    int mon_st_cnt = 0, mon_st_addr = 0, mon_st_delta = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) check("s_ready_busy", 32'(s_ready), 32'(sess_acc < m_consumed));
            if (wr_en) begin
                mon_wa.push_back(int'(wr_addr));
                mon_wd.push_back(int'(wr_data));
                mon_wc.push_back(cyc);
                check("wr_latency", cyc - last_acc_cyc, 1);
            end
            if (start) begin
                mon_st_cnt++;
                mon_st_addr  = int'(start_addr);
                mon_st_delta = cyc - last_acc_cyc;
                check("start_with_wr_en", 32'(wr_en), 0);
            end
            if (s_valid && s_ready) begin
                sess_acc++;
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic pulse_load();
        @(posedge clk); #1;
        load     = 1'b1;
        sess_acc = 0;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Offer bytes 0..count-1; mode 0 = valid held, 1 = toggling, 2 = random.
    task automatic drive_bytes(input string name, input int count, input int mode, input bit noisy);
        int i = 0;
        int t = 0;
        while (i < count && t < 400) begin
            s_data = stim[i];
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (t % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            load = noisy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        s_valid = 1'b0;
        load    = 1'b0;
        check({name, "_bytes_taken"}, i, count);
    endtask

    task automatic run_session(input string name, input int mode, input bit noisy);
        build_model();
        mon_wa.delete();
        mon_wd.delete();
        mon_wc.delete();
        mon_st_cnt = 0;
        pulse_load();
        drive_bytes(name, m_consumed, mode, noisy);
        repeat (6) @(posedge clk);
        #1;
        check({name, "_wr_count"}, mon_wa.size(), m_wa.size());
        for (int k = 0; k < m_wa.size() && k < mon_wa.size(); k++) begin
            check({name, "_wr_addr"}, mon_wa[k], m_wa[k]);
            check({name, "_wr_data"}, mon_wd[k], m_wd[k]);
            if (mode == 0 && k > 0) check({name, "_wr_spacing"}, mon_wc[k] - mon_wc[k-1], 2);
        end
        check({name, "_start_count"}, mon_st_cnt, m_err ? 0 : 1);
        if (!m_err && mon_st_cnt == 1) begin
            check({name, "_start_addr"}, mon_st_addr, m_base);
            check({name, "_start_delay"}, mon_st_delta, (m_n == 0) ? 1 : 2);
        end
        check({name, "_error"}, 32'(error), 32'(m_err));
        check({name, "_busy_end"}, 32'(busy), 0);
        check({name, "_s_ready_end"}, 32'(s_ready), 0);
    endtask

    initial begin
        int n, b, kind, bad_k;

        // Reset state.
        #12;
        check("reset_outputs", {s_ready, wr_en, wr_addr, wr_data, start, start_addr, busy, error}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-stream: header taken, loader waiting in the data phase.
        load_stim(10, 80'h03_00_10_00_34_01_FF_00_00_01);
        build_model();
        mon_wa.delete();
        mon_st_cnt = 0;
        pulse_load();
        drive_bytes("abort", 4, 0, 1'b0);
        check("abort_in_data", {30'd0, busy, s_ready}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_outputs", {s_ready, wr_en, wr_addr, wr_data, start, start_addr, busy, error}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_activity", mon_wa.size() + mon_st_cnt, 0);

        // Directed sessions.
        load_stim(10, 80'h03_00_10_00_34_01_FF_00_00_01);
        run_session("b2b", 0, 1'b0);
        run_session("toggle", 1, 1'b0);
        load_stim(4, 32'h00_00_05_00);
        run_session("n_zero", 0, 1'b0);
        load_stim(4, 32'h02_00_FF_01);
        run_session("range_err", 0, 1'b0);
        load_stim(8, 64'h02_00_FE_01_12_00_34_01);
        run_session("top_fit", 0, 1'b0);
        load_stim(10, 80'h03_00_10_00_34_01_FF_00_00_01);
        run_session("noisy_load", 2, 1'b1);
        load_stim(6, 48'h01_00_00_00_12_02);
        run_session("bad_hi", 0, 1'b0);

        // Randomized sessions.
        for (int s = 0; s < 25; s++) begin
            n     = $urandom_range(0, 6);
            kind  = $urandom_range(0, 5);
            bad_k = (n > 0) ? $urandom_range(0, n - 1) : 0;
            if (kind == 0) b = ROM_SIZE - n + 1 + $urandom_range(0, 3);
            else           b = $urandom_range(0, ROM_SIZE - n);
            stim.delete();
            stim.push_back(8'(n));
            stim.push_back(8'(n >> 8));
            stim.push_back(8'(b));
            stim.push_back(8'(b >> 8));
            for (int k = 0; k < n; k++) begin
                stim.push_back(8'($urandom_range(0, 255)));
                if (kind == 1 && k == bad_k) stim.push_back(8'($urandom_range(2, 255)));
                else                         stim.push_back(8'($urandom_range(0, 1)));
            end
            run_session("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side counterpart of the instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions.
- Writes them into instruction memory through its write port, then pulses start/start_addr to launch the program counter at the loaded base address.
- Sits between the bench/host byte source and the instruction memory plus program counter.

Parameters:
rom_size, 512, instruction memory depth in words
instr_width, 9, instruction width in bits
byte_width, 8, stream byte width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle pulse; begins a load session
s_data  input  byte_width  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe
wr_addr  output  $clog2(rom_size)+1  instruction memory write address
wr_data  output  instr_width  instruction memory write data
start  output  1  one-cycle pulse to program counter
start_addr  output  $clog2(rom_size)+1  program counter start address, valid while start is high
busy  output  1  high from load accepted until start or error
error  output  1  sticky malformed-stream flag

Behaviour:
- Reset (async, rst_n low) drives these outputs to 0 and forces state IDLE:
  - s_ready, wr_en, wr_addr, wr_data, start, start_addr, busy, error.
- A byte transfers only on a rising clk with s_valid && s_ready. s_ready is high only in the header and data states. s_data is ignored otherwise.
- Stream format, little-endian, in order:
  - LEN_LO, LEN_HI: 16-bit instruction count N.
  - BASE_LO, BASE_HI: 16-bit base address B.
  - Then N instruction pairs: LO = bits [7:0], HI = bit 0 is instruction bit 8; HI bits [7:1] must be 0.
- States and transitions:
  - IDLE: load=1 -> LEN_LO; clear error; busy=1.
  - LEN_LO -> LEN_HI -> BASE_LO -> BASE_HI, one per accepted byte.
  - BASE_HI on accept: if B+N > rom_size (17-bit compare) -> ERROR. Else if N==0 -> LAUNCH. Else -> DATA_LO.
  - DATA_LO -> DATA_HI on accept.
  - DATA_HI on accept: if HI[7:1]!=0 -> ERROR, with no write issued. Else register the write and go to DATA_LO, or to LAUNCH when it was the last pair.
  - LAUNCH: start=1 and start_addr=B for exactly one cycle; busy=0 next cycle; -> IDLE.
  - ERROR: error=1 (sticky), busy=0, s_ready=0. Only load=1 -> LEN_LO, which clears error.
- Write timing:
  - wr_en is a registered one-cycle pulse in the cycle after the HI byte is accepted.
  - wr_data = {HI[0], LO}; wr_addr = B + index, where index counts 0..N-1.
  - wr_addr and wr_data hold their last values when wr_en=0.
- Start timing: start asserts the cycle after the last wr_en pulse, or the cycle after BASE_HI is accepted when N==0. It never coincides with wr_en.
- Back-to-back: with s_valid held high, one byte is accepted per cycle, giving one write per two cycles.
- load while busy is ignored. load in the same cycle as LAUNCH is ignored.
- rst_n asserted mid-session aborts immediately: no further writes and no start. Memory contents already written are not reverted.
- Address arithmetic is (clog2(rom_size)+1) bits wide; the range check guarantees no wrap.

Test Plan:
1. Reset mid-stream: assert rst_n=0 during DATA_LO -> all outputs 0 asynchronously; a later load restarts cleanly.
2. load, stream 03 00 10 00 | 34 01 | FF 00 | 00 01, s_valid held high -> writes:
   - (16, 0x134), (17, 0x0FF), (18, 0x100), each wr_en one cycle, spaced two cycles apart.
   - Then start=1 with start_addr=16 the cycle after the third write; busy falls next cycle.
3. Same stream with s_valid toggling 1/0 every cycle -> identical writes and start; no byte is lost or duplicated; s_ready never drops except in IDLE/LAUNCH.
4. N=0, B=5 (00 00 05 00) -> no wr_en; start=1, start_addr=5 one cycle after the fourth byte.
5. Range error N=2, B=511 (rom_size 512): 02 00 FF 01 -> error=1, busy=0, s_ready=0, no writes, no start. A subsequent load clears error and a valid load succeeds.
6. Bad HI byte: N=1, B=0, pair 12 02 -> error=1, no wr_en, no start. load pulsed during the preceding busy session had no effect.
